// File: rtl/anc_pkg.sv
// Shared types and helpers for the ANC output mixer: sample type, pairing
// state enum, clamp limits and the saturating subtract used by anc_sat_sub.
package anc_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ANTI,
    WAIT_MUSIC
  } mix_state_t;

  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  // Both operands sign-extend to 17 bits, so the difference never wraps;
  // bits 16 and 15 disagree exactly when the result leaves the 16-bit range.
  function automatic sample_t sat_sub(input sample_t a, input sample_t b);
    logic signed [16:0] d;
    d = {a[15], a} - {b[15], b};
    if (d[16] != d[15]) return d[16] ? SAMPLE_MIN : SAMPLE_MAX;
    return sample_t'(d[15:0]);
  endfunction

endpackage

// File: rtl/anc_sat_sub.sv
// Combinational 17-bit subtract-and-clamp: diff = sat(a - b).
module anc_sat_sub
  import anc_pkg::*;
(
  input  sample_t a,
  input  sample_t b,
  output sample_t diff
);

  assign diff = sat_sub(a, b);

endmodule

// File: rtl/anc_mixer.sv
// Pairs music and anti-noise samples and emits saturated music - anti-noise,
// timing out unpaired samples. ANC_MIXER_STATS_EN adds the drop counter port.
module anc_mixer
  import anc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [15:0] music_in,
  input  logic        music_valid_in,
  input  logic [15:0] anti_in,
  input  logic        anti_valid_in,
  input  logic        anc_enable_in,
  output logic [15:0] signal_out,
  output logic        done_out
`ifdef ANC_MIXER_STATS_EN
  ,
  output logic [15:0] drop_count_out
`endif
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  mix_state_t  state;
  logic [15:0] timer;
  sample_t     held_music;
  sample_t     held_anti;

  logic    timer_done;
  logic    complete;
  sample_t op_music;
  sample_t op_anti;
  sample_t op_anti_eff;
  sample_t mixed;

  // The last wait cycle is the one in which the timer reads TIMEOUT_CYCLES-1.
  assign timer_done = (timer == TIMER_LAST);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    complete = 1'b0;
    op_music = '0;
    op_anti  = '0;
    unique case (state)
      IDLE: begin
        if (music_valid_in && anti_valid_in) begin
          complete = 1'b1;
          op_music = sample_t'(music_in);
          op_anti  = sample_t'(anti_in);
        end
      end
      WAIT_ANTI: begin
        if (anti_valid_in) begin
          complete = 1'b1;
          op_music = held_music;
          op_anti  = sample_t'(anti_in);
        end else if (!music_valid_in && timer_done) begin
          complete = 1'b1;
          op_music = held_music;
        end
      end
      WAIT_MUSIC: begin
        if (music_valid_in) begin
          complete = 1'b1;
          op_music = sample_t'(music_in);
          op_anti  = held_anti;
        end else if (!anti_valid_in && timer_done) begin
          complete = 1'b1;
          op_anti  = held_anti;
        end
      end
      default: ;
    endcase
  end

  assign op_anti_eff = anc_enable_in ? op_anti : '0;

  anc_sat_sub u_sat_sub (
    .a    (op_music),
    .b    (op_anti_eff),
    .diff (mixed)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state      <= IDLE;
      timer      <= '0;
      held_music <= '0;
      held_anti  <= '0;
      signal_out <= '0;
      done_out   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge value, so ordering inside this block does not matter.
      done_out <= complete;
      if (complete) signal_out <= mixed;
      unique case (state)
        IDLE: begin
          timer <= '0;
          if (music_valid_in && !anti_valid_in) begin
            held_music <= sample_t'(music_in);
            state      <= WAIT_ANTI;
          end else if (anti_valid_in && !music_valid_in) begin
            held_anti <= sample_t'(anti_in);
            state     <= WAIT_MUSIC;
          end
        end
        WAIT_ANTI: begin
          // A new music strobe either overwrites or re-arms after a pair.
          if (music_valid_in) begin
            held_music <= sample_t'(music_in);
            timer      <= '0;
          end else if (anti_valid_in || timer_done) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        WAIT_MUSIC: begin
          if (anti_valid_in) begin
            held_anti <= sample_t'(anti_in);
            timer     <= '0;
          end else if (music_valid_in || timer_done) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

`ifdef ANC_MIXER_STATS_EN
  logic drop;

  // Drop = overwrite of the held sample, or a timeout without a partner.
  assign drop = ((state == WAIT_ANTI) && !anti_valid_in && (music_valid_in || timer_done))
             || ((state == WAIT_MUSIC) && !music_valid_in && (anti_valid_in || timer_done));

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      drop_count_out <= '0;
    end else if (drop && (drop_count_out != 16'hFFFF)) begin
      drop_count_out <= drop_count_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_anc_mixer.sv
// Scoreboard bench for anc_mixer: directed stimulus pushes expected samples
// with their due cycle; a monitor pops and compares on every done_out.
module tb_anc_mixer;

  localparam int TO = 16;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [15:0] music_in;
  logic        music_valid_in;
  logic [15:0] anti_in;
  logic        anti_valid_in;
  logic        anc_enable_in;
  logic [15:0] signal_out;
  logic        done_out;
`ifdef ANC_MIXER_STATS_EN
  logic [15:0] drop_count_out;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   drive_cyc = 0;
  logic en = 1'b1;
  exp_t q[$];

  anc_mixer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in         (clk),
    .reset_in       (reset_in),
    .music_in       (music_in),
    .music_valid_in (music_valid_in),
    .anti_in        (anti_in),
    .anti_valid_in  (anti_valid_in),
    .anc_enable_in  (anc_enable_in),
    .signal_out     (signal_out),
    .done_out       (done_out)
`ifdef ANC_MIXER_STATS_EN
    ,
    .drop_count_out (drop_count_out)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step(input logic mv, input int m, input logic av, input int a);
    @(negedge clk);
    music_valid_in = mv;
    music_in       = 16'(m);
    anti_valid_in  = av;
    anti_in        = 16'(a);
    anc_enable_in  = en;
    drive_cyc      = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 1'b0, 0);
  endtask

  task automatic expect_out(input int val, input int dly);
    q.push_back('{val: val, cyc: drive_cyc + dly});
  endtask

  task automatic check_drops(input int exp);
`ifdef ANC_MIXER_STATS_EN
    check("drop_count", int'(drop_count_out), exp);
`else
    if (exp < 0) $display("negative drop expectation %0d", exp);
`endif
  endtask

  // Monitor: every done_out must match the head of the scoreboard, on time.
  always @(negedge clk) begin
    if (done_out) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got signal_out=%0d, expected no output (cycle %0d)",
                 $signed(signal_out), cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_value", int'($signed(signal_out)), e.val);
        check("out_cycle", cyc, e.cyc);
      end
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      $display("FAIL missing_done: got none, expected %0d at cycle %0d", e.val, e.cyc);
    end
  end

  initial begin
    reset_in       = 1'b1;
    music_valid_in = 1'b0;
    anti_valid_in  = 1'b0;
    music_in       = '0;
    anti_in        = '0;
    anc_enable_in  = 1'b1;
    repeat (3) @(negedge clk);
    reset_in = 1'b0;
    check("reset_signal", int'(signal_out), 0);
    check("reset_done", int'(done_out), 0);
    check_drops(0);

    // Same-cycle pair.
    step(1'b1, 1000, 1'b1, 300); expect_out(700, 1);
    idle(2);

    // Separated pairs with saturation both ways.
    step(1'b1, 32000, 1'b0, 0); idle(4);
    step(1'b0, 0, 1'b1, -2000); expect_out(32767, 1);
    idle(2);
    step(1'b1, -32000, 1'b0, 0); idle(4);
    step(1'b0, 0, 1'b1, 2000); expect_out(-32768, 1);
    idle(2);

    // Enable low ignores anti-noise; then enabled again.
    en = 1'b0;
    step(1'b0, 0, 1'b1, 500); idle(2);
    step(1'b1, 100, 1'b0, 0); expect_out(100, 1);
    idle(1);
    en = 1'b1;
    step(1'b1, 100, 1'b1, 500); expect_out(-400, 1);
    idle(2);

    // Timeout of held music.
    step(1'b1, 1234, 1'b0, 0); expect_out(1234, TO + 1);
    idle(TO + 4);
    check_drops(1);

    // Partner arrives in the last wait cycle: normal pair, no drop.
    step(1'b1, 777, 1'b0, 0); idle(TO - 1);
    step(1'b0, 0, 1'b1, 77); expect_out(700, 1);
    idle(3);
    check_drops(1);

    // Timeout of held anti-noise: music treated as 0.
    step(1'b0, 0, 1'b1, 250); expect_out(-250, TO + 1);
    idle(TO + 4);
    check_drops(2);

    // Overwrite of held music.
    step(1'b1, 10, 1'b0, 0);
    step(1'b1, 20, 1'b0, 0);
    step(1'b0, 0, 1'b1, 5); expect_out(15, 1);
    idle(2);
    check_drops(3);

    // Pair plus new capture in one cycle, then pair the new music.
    step(1'b1, 10, 1'b0, 0);
    step(1'b1, 40, 1'b1, 5); expect_out(5, 1);
    step(1'b0, 0, 1'b1, 0); expect_out(40, 1);
    idle(2);
    check_drops(3);

    // Back-to-back full throughput, including extreme operands.
    step(1'b1, 5, 1'b1, 2); expect_out(3, 1);
    step(1'b1, -7, 1'b1, 3); expect_out(-10, 1);
    step(1'b1, 32767, 1'b1, -32768); expect_out(32767, 1);
    step(1'b1, -32768, 1'b1, 32767); expect_out(-32768, 1);
    idle(2);

    // Reset in WAIT_MUSIC with a coincident music strobe that must be ignored.
    step(1'b0, 0, 1'b1, 123); idle(2);
    @(negedge clk);
    reset_in       = 1'b1;
    music_valid_in = 1'b1;
    music_in       = 16'd999;
    @(negedge clk);
    reset_in       = 1'b0;
    music_valid_in = 1'b0;
    check("rst_wait_signal", int'(signal_out), 0);
    check("rst_wait_done", int'(done_out), 0);
    check_drops(0);

    // A lone music strobe now waits alone and times out with no partner.
    step(1'b1, -50, 1'b0, 0); expect_out(-50, TO + 1);
    idle(TO + 6);
    check_drops(1);

    check("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
